// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, drives the synchronous-read imem, and
// queues returned words (with their PCs) in a small FIFO toward decode.
module ifetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_dout_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    input  logic              ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       pc_reg, pc_next;
    logic              inflight_reg, inflight_next;
    logic [31:0]       inflight_pc_reg, inflight_pc_next;

    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [31:0]       pc_mem    [DEPTH];
    logic [DEPTH-1:0]  wr_en;

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic [1:0]        unused_pc_bits;

    assign unused_pc_bits = redirect_pc_i[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign imem_addr_o = pc_reg[ADDR_W+1:2];

    assign valid_o = (count_reg != '0);
    assign instr_o = valid_o ? instr_mem[head_reg] : '0;
    assign pc_o    = valid_o ? pc_mem[head_reg]    : '0;

    assign pop  = valid_o & ready_i;
    // A word returning in a redirect cycle belongs to the abandoned path.
    assign push = inflight_reg & ~redirect_i;

    // Buffered words plus the one in flight, after this cycle's pop, must leave room.
    assign occupancy = {1'b0, count_reg} + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
    assign issue     = ~redirect_i & (occupancy < (CNT_W + 1)'(DEPTH));

    always_comb begin
        pc_next          = pc_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        if (redirect_i) begin
            pc_next = {redirect_pc_i[31:2], 2'b00};
        end else if (issue) begin
            inflight_next    = 1'b1;
            inflight_pc_next = pc_reg;
            pc_next          = pc_reg + 32'd4;
        end
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (redirect_i) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                tail_next = ptr_inc(tail_reg);
            end
            if (pop) begin
                head_next = ptr_inc(head_reg);
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
        end else begin
            pc_reg          <= pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push & (tail_reg == PTR_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (wr_en[gi]) begin
                    instr_mem[gi] <= imem_dout_i;
                    pc_mem[gi]    <= inflight_pc_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit: expected (pc, instr) stream is queued by
// the stimulus side from program-order rules; a negedge monitor checks every accepted word.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0FF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready = 1'b1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] gen_pc;
    int          total = 0;
    int          bad = 0;

    ifetch_unit #(
        .ADDR_W(10),
        .DATA_W(32),
        .RESET_PC(RST_PC),
        .DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr_o(imem_addr),
        .imem_dout_i(imem_dout),
        .redirect_i(redirect),
        .redirect_pc_i(redirect_pc),
        .instr_o(instr),
        .pc_o(pc),
        .valid_o(valid),
        .ready_i(ready)
    );

    always #5 clk = ~clk;

    // ROM contents: word i holds A000_0000 + i, one-cycle synchronous read.
    always @(posedge clk) imem_dout <= 32'hA000_0000 + {22'b0, imem_addr};

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [9:0] w;
        w = a[11:2];
        return 32'hA000_0000 + {22'b0, w};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic topup();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc    = gen_pc;
            e.instr = rom_word(gen_pc);
            exp_q.push_back(e);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] p);
        exp_q.delete();
        gen_pc = {p[31:2], 2'b00};
        topup();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    // Redirect in the current cycle; returns one cycle later with the new stream queued.
    task automatic do_redirect(input logic [31:0] tgt);
        redirect    = 1'b1;
        redirect_pc = tgt;
        step();
        redirect = 1'b0;
        restart(tgt);
    endtask

    task automatic redirect_check(input logic [31:0] tgt);
        logic [31:0] a;
        a = {tgt[31:2], 2'b00};
        do_redirect(tgt);
        @(negedge clk);
        check("redir_valid_r1", {31'b0, valid}, 32'd0);
        step();
        @(negedge clk);
        check("redir_valid_r2", {31'b0, valid}, 32'd0);
        step();
        @(negedge clk);
        check("redir_valid_r3", {31'b0, valid}, 32'd1);
        check("redir_pc_r3", pc, a);
        check("redir_instr_r3", instr, rom_word(a));
        step();
    endtask

    task automatic release_reset();
        ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_valid_c0", {31'b0, valid}, 32'd0);
        step();
        @(negedge clk);
        check("rel_valid_c1", {31'b0, valid}, 32'd0);
        step();
        @(negedge clk);
        check("rel_valid_c2", {31'b0, valid}, 32'd1);
        check("rel_pc_c2", pc, RST_PC);
        check("rel_instr_c2", instr, rom_word(RST_PC));
        step();
    endtask

    // Monitor: every accepted word must be the next expected one; a stalled head must hold.
    logic        hold_pending = 1'b0;
    logic [31:0] hold_instr = 32'h0;
    logic [31:0] hold_pc = 32'h0;
    int          idle = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
            idle = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'b0, valid}, 32'd1);
                check("hold_instr", instr, hold_instr);
                check("hold_pc", pc, hold_pc);
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty: got pc %h, required no output", pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stream_pc", pc, mon_e.pc);
                    check("stream_instr", instr, mon_e.instr);
                end
            end
            hold_pending = valid && !ready && !redirect;
            hold_instr   = instr;
            hold_pc      = pc;
            if (valid || redirect || !ready) idle = 0;
            else idle++;
            check("liveness", {31'b0, (idle > 3)}, 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish, required finish before 400000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] tgt;
        restart(RST_PC);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_addr", {22'b0, imem_addr}, 32'h3FE);
        step();

        // Start near the top of the ROM: FF8, FFC, 1000 wraps the word address.
        release_reset();
        step();
        step();

        // Five-cycle stall with a full FIFO: fetch address must park two words past the head.
        ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        tgt = exp_q[0].pc + 32'd8;
        check("stall_addr", {22'b0, imem_addr}, {22'b0, tgt[11:2]});
        step();
        ready = 1'b1;
        repeat (6) step();

        // Redirect while a word is being consumed, then back-to-back redirects.
        redirect_check(32'h0000_0103);
        step();
        do_redirect(32'h0000_0200);
        redirect_check(32'h0000_0300);
        repeat (3) step();

        for (int i = 0; i < 1500; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 1) == 1) tgt = $urandom;
                else tgt = 32'h0000_0FF0 + $urandom_range(0, 15);
                do_redirect(tgt);
            end else begin
                step();
            end
        end

        // Asynchronous reset mid-cycle with the FIFO full.
        ready = 1'b1;
        repeat (4) step();
        ready = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        restart(RST_PC);
        #1;
        check("async_rst_valid", {31'b0, valid}, 32'd0);
        check("async_rst_instr", instr, 32'd0);
        check("async_rst_addr", {22'b0, imem_addr}, 32'h3FE);
        step();
        step();
        release_reset();
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
